// File: rtl/fp_div_seq.sv
// Sequential FP32/FP16 divider z = x / y. It uses a restoring radix-2 mantissa loop
// that produces one quotient bit per cycle, and a single normalize/round/pack cycle.
module fp_div_seq #(
  parameter int GUARD_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z
);

  localparam int QW = 25 + GUARD_BITS;
  localparam logic [4:0] LAST32 = 5'(QW - 1);
  localparam logic [4:0] LAST16 = 5'(12 + GUARD_BITS - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state, state_nx;

  logic              mode_r, sz_r, x_zero_r, y_zero_r;
  logic signed [9:0] e_r;
  logic [24:0]       rem_r;
  logic [23:0]       dv_r;
  logic [QW-1:0]     q_r;
  logic [4:0]        cnt_r;
  logic [31:0]       z_r;

  // A transfer happens on a rising edge where valid && ready. The producer holds its
  // data until then. The divider raises in_ready only in IDLE and raises out_valid
  // only in DONE, so accepting operands and delivering a result never share a cycle.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign z         = z_r;

  logic              sx, sy;
  logic [7:0]        ex, ey;
  logic [23:0]       mx, my;
  logic signed [9:0] bias, e_in;

  always_comb begin
    if (mode) begin
      sx = x[31];  sy = y[31];
      ex = x[30:23];  ey = y[30:23];
      mx = {1'b1, x[22:0]};  my = {1'b1, y[22:0]};
      bias = 10'sd127;
    end else begin
      sx = x[15];  sy = y[15];
      ex = {3'b000, x[14:10]};  ey = {3'b000, y[14:10]};
      mx = {13'd0, 1'b1, x[9:0]};  my = {13'd0, 1'b1, y[9:0]};
      bias = 10'sd15;
    end
    if (ex == 8'd0) mx = '0;
    if (ey == 8'd0) my = '0;
    e_in = $signed({2'b00, ex}) - $signed({2'b00, ey}) + bias;
  end

  logic        ge;
  logic [24:0] rem_sub;

  assign ge      = (rem_r >= {1'b0, dv_r});
  assign rem_sub = ge ? (rem_r - {1'b0, dv_r}) : rem_r;

  // FP16 quotients sit in the low 14 bits of q, so they are aligned to the FP32 layout first.
  logic [QW-1:0]     qa, qn;
  logic              norm_shift, rem_nz, lsb, g, r, st, up, carry32, carry16;
  logic [22:0]       frac32;
  logic [9:0]        frac16;
  logic signed [9:0] e_n, e_f;
  logic              is_inf, is_zero;
  logic [31:0]       z_nx;

  always_comb begin
    qa         = mode_r ? q_r : (q_r << (QW - 14));
    norm_shift = ~qa[QW-1];
    qn         = norm_shift ? (qa << 1) : qa;
    e_n        = e_r - (norm_shift ? 10'sd1 : 10'sd0);
    rem_nz     = |rem_r;
    if (mode_r) begin
      lsb = qn[3];   g = qn[2];   r = qn[1];   st = qn[0] | rem_nz;
    end else begin
      lsb = qn[16];  g = qn[15];  r = qn[14];  st = (|qn[13:0]) | rem_nz;
    end
    up      = g & (r | st | lsb);
    // An all-ones mantissa rounds up to 1.0. The fraction wraps to zero and the exponent steps up.
    frac32  = qn[25:3] + {22'd0, up};
    carry32 = up & (&qn[26:3]);
    frac16  = qn[25:16] + {9'd0, up};
    carry16 = up & (&qn[26:16]);
    e_f     = e_n + ((mode_r ? carry32 : carry16) ? 10'sd1 : 10'sd0);

    is_inf  = 1'b0;
    is_zero = 1'b0;
    if (y_zero_r)                                   is_inf  = 1'b1;
    else if (x_zero_r)                              is_zero = 1'b1;
    else if (e_f >= (mode_r ? 10'sd255 : 10'sd31))  is_inf  = 1'b1;
    else if (e_f <= 10'sd0)                         is_zero = 1'b1;

    if (mode_r)
      z_nx = is_inf  ? {sz_r, 8'hFF, 23'd0} :
             is_zero ? {sz_r, 31'd0} : {sz_r, e_f[7:0], frac32};
    else
      z_nx = {16'd0, is_inf  ? {sz_r, 5'h1F, 10'd0} :
                     is_zero ? {sz_r, 15'd0} : {sz_r, e_f[4:0], frac16}};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = DIV;
      DIV:     if (cnt_r == (mode_r ? LAST32 : LAST16)) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      z_r      <= '0;
      cnt_r    <= '0;
      mode_r   <= 1'b0;
      sz_r     <= 1'b0;
      x_zero_r <= 1'b0;
      y_zero_r <= 1'b0;
      e_r      <= '0;
      rem_r    <= '0;
      dv_r     <= '0;
      q_r      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          mode_r   <= mode;
          sz_r     <= sx ^ sy;
          x_zero_r <= (ex == 8'd0);
          y_zero_r <= (ey == 8'd0);
          e_r      <= e_in;
          rem_r    <= {1'b0, mx};
          dv_r     <= my;
          q_r      <= '0;
          cnt_r    <= '0;
        end
        DIV: begin
          q_r   <= {q_r[QW-2:0], ge};
          rem_r <= rem_sub << 1;
          cnt_r <= cnt_r + 5'd1;
        end
        NORM:    z_r <= z_nx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq. It checks the quotient, fixed latency, busy window,
// output backpressure and reset abort.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        in_ready, out_valid;
  logic [31:0] z;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp_div_seq #(.GUARD_BITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one operand pair, which must be accepted in the first cycle. It returns #1 after the accept edge.
  task automatic send(input logic m, input logic [31:0] xv, input logic [31:0] yv, input string tag);
    in_valid = 1'b1;  mode = m;  x = xv;  y = yv;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = 1'($urandom_range(0, 1));
    x = $urandom;
    y = $urandom;
  endtask

  // Waits for the result, checks it, holds it for 'hold' cycles, then completes the handshake.
  task automatic recv(input logic m, input string tag, input int hold);
    int lat, busy;
    logic [31:0] exp_z;
    exp_z = exp_q.pop_front();
    lat = 1;
    busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy++;
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), m ? 32'd29 : 32'd16);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_z"}, z, exp_z);
    check({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_z"}, z, exp_z);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input logic m, input logic [31:0] xv, input logic [31:0] yv,
                     input logic [31:0] ez, input string tag, input int hold);
    exp_q.push_back(ez);
    send(m, xv, yv, tag);
    recv(m, tag, hold);
  endtask

  initial begin
    int ov;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", z, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, "f32_6_div_2", 0);
    run(1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "f32_1_div_3", 0);
    run(1'b1, 32'hC0F00000, 32'h40200000, 32'hC0400000, "f32_neg_7p5_div_2p5", 0);
    run(1'b0, 32'h00003C00, 32'h00004200, 32'h00003555, "f16_1_div_3", 0);
    run(1'b0, 32'hABCD4600, 32'h12344000, 32'h00004200, "f16_upper_ignored", 0);
    run(1'b1, 32'hBF800000, 32'h00000000, 32'hFF800000, "f32_div_by_zero", 0);
    run(1'b1, 32'h00000000, 32'h40A00000, 32'h00000000, "f32_zero_dividend", 0);
    run(1'b1, 32'h80000000, 32'h40000000, 32'h80000000, "f32_neg_zero", 0);
    run(1'b1, 32'h7F000000, 32'h3E800000, 32'h7F800000, "f32_overflow", 0);
    run(1'b1, 32'h7F000000, 32'h3F800000, 32'h7F000000, "f32_max_exp", 0);
    run(1'b1, 32'h00800000, 32'h40000000, 32'h00000000, "f32_underflow_e0", 0);
    run(1'b1, 32'h01000000, 32'h40000000, 32'h00800000, "f32_min_normal", 0);
    run(1'b0, 32'h00000000, 32'h00000000, 32'h00007C00, "f16_zero_div_zero", 0);
    run(1'b0, 32'h00008400, 32'h00007800, 32'h00008000, "f16_underflow", 0);
    run(1'b0, 32'h00007800, 32'h00000400, 32'h00007C00, "f16_overflow", 0);

    // Backpressure, then an immediate second op in the other mode.
    run(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, "bp_f32", 5);
    run(1'b0, 32'h00004600, 32'h00004000, 32'h00004200, "b2b_f16", 0);

    // Abort with a one-cycle reset in the tenth DIV cycle.
    send(1'b1, 32'h40C00000, 32'h40000000, "abort");
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_in_ready", 32'(in_ready), 32'd0);
    check("abort_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    ov = 0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("abort_no_out_valid", 32'(ov), 32'd0);
    @(posedge clk); #1;
    run(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, "after_abort", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
